// File: rtl/char_seq_loader.sv
// char_seq_loader: packs a byte-serial stream of character IDs into N-char words,
// ping-pong buffered, presented as the emb_layer forward operand.
module char_seq_loader #(
  parameter int N         = 4,
  parameter int CHAR_LEN  = 8,
  parameter int CHAR_NUM  = 200,
  parameter int PAD_ID    = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  input  logic [CHAR_LEN-1:0]   s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  q_valid,
  input  logic                  q_ready,
  output logic [N*CHAR_LEN-1:0] q,
  output logic                  err_short,
  output logic                  err_long,
  output logic                  err_range,
  output logic [CNT_WIDTH-1:0]  seq_cnt
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int W  = N * CHAR_LEN;
  typedef enum logic {FILL, DISCARD} state_t;
  state_t state, state_nx;
  logic live;
  logic [1:0][W-1:0] slot;
  logic [1:0] slot_valid;
  logic wr_sel, rd_sel;
  logic [IW-1:0] idx;
  logic long_seen;
  logic acc, fill_acc, at_end, complete, short_seq, bad_id, pop;
  logic [CHAR_LEN-1:0] id;
  assign acc       = s_valid & s_ready;
  assign fill_acc  = acc & (state == FILL);
  assign at_end    = idx == IW'(N - 1);
  assign complete  = fill_acc & (s_last | at_end);
  assign short_seq = fill_acc & s_last & ~at_end;
  assign bad_id    = 32'(s_data) >= 32'(CHAR_NUM);
  assign id        = bad_id ? CHAR_LEN'(PAD_ID) : s_data;
  assign pop       = q_ready & q_valid;
  assign q         = slot[rd_sel];
  assign q_valid   = slot_valid[rd_sel];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FILL;
    else state <= state_nx;
  always_comb begin
    state_nx = state == FILL ? ((fill_acc & at_end & ~s_last) ? DISCARD : FILL)
                             : ((acc & s_last) ? FILL : DISCARD);
  end
  // live holds s_ready low until the first cycle after reset release
  always_comb begin
    s_ready = live & ((state == DISCARD) | ~slot_valid[wr_sel]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live       <= 1'b0;
      slot       <= '0;
      slot_valid <= 2'b00;
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b0;
      idx        <= '0;
      seq_cnt    <= '0;
      long_seen  <= 1'b0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      err_range  <= 1'b0;
    end else begin
      live <= 1'b1;
      // a short sequence pads every position after the last character in the same cycle
      for (int k = 0; k < N; k++)
        if (fill_acc && (k == int'(idx) || (s_last && k > int'(idx))))
          slot[wr_sel][k*CHAR_LEN +: CHAR_LEN] <= k == int'(idx) ? id : CHAR_LEN'(PAD_ID);
      slot_valid <= (slot_valid & ~(pop ? 2'b01 << rd_sel : 2'b00)) | (complete ? 2'b01 << wr_sel : 2'b00);
      wr_sel     <= wr_sel ^ complete;
      rd_sel     <= rd_sel ^ pop;
      idx        <= complete ? '0 : fill_acc ? idx + IW'(1) : idx;
      seq_cnt    <= seq_cnt + CNT_WIDTH'(complete);
      long_seen  <= (state == DISCARD) & (long_seen | acc) & ~(acc & s_last);
      err_short  <= short_seq;
      err_long   <= (state == DISCARD) & acc & ~long_seen;
      err_range  <= fill_acc & bad_id;
    end
  end
endmodule

// File: tb/tb_char_seq_loader.sv
// tb_char_seq_loader: directed checks of char_seq_loader with N=4, CHAR_LEN=8, CHAR_NUM=200.
module tb_char_seq_loader;
  logic clk = 1'b0, rst_n = 1'b0;
  logic s_valid = 1'b0, s_last = 1'b0, q_ready = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic s_ready, q_valid, err_short, err_long, err_range;
  logic [31:0] q;
  logic [15:0] seq_cnt;
  int checks = 0, errors = 0;

  char_seq_loader #(.N(4), .CHAR_LEN(8), .CHAR_NUM(200), .PAD_ID(0), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .q_valid(q_valid), .q_ready(q_ready), .q(q),
    .err_short(err_short), .err_long(err_long), .err_range(err_range), .seq_cnt(seq_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data = d;
    s_last = last;
    while (!s_ready && n < 50) begin
      cyc();
      n++;
    end
    check("beat_wait", n >= 50, 0);
    cyc();
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic pop();
    q_ready = 1'b1;
    cyc();
    q_ready = 1'b0;
  endtask

  initial begin
    cyc();
    check("rst_s_ready", s_ready, 0);
    check("rst_q_valid", q_valid, 0);
    check("rst_q", q, 0);
    check("rst_seq_cnt", seq_cnt, 0);
    check("rst_errs", {err_short, err_long, err_range}, 0);
    rst_n = 1'b1;
    cyc();
    check("post_rst_s_ready", s_ready, 1);

    // 1: plain full sequence
    beat(8'h03, 0); beat(8'h07, 0); beat(8'h09, 0); beat(8'h0B, 1);
    check("t1_q_valid", q_valid, 1);
    check("t1_q", q, 32'h0B090703);
    check("t1_s_ready", s_ready, 1);
    check("t1_seq_cnt", seq_cnt, 1);
    check("t1_err_short", err_short, 0);
    pop();
    check("t1_pop_q_valid", q_valid, 0);

    // 2: both slots fill, input stalls, then drain
    beat(8'h01, 0); beat(8'h02, 0); beat(8'h03, 0); beat(8'h04, 1);
    beat(8'h05, 0); beat(8'h06, 0); beat(8'h07, 0); beat(8'h08, 1);
    check("t2_s_ready_full", s_ready, 0);
    s_valid = 1'b1; s_data = 8'h09;
    cyc(); cyc();
    check("t2_stall", s_ready, 0);
    check("t2_q_held", q, 32'h04030201);
    s_valid = 1'b0;
    check("t2_seq_cnt", seq_cnt, 3);
    pop();
    check("t2_q_second", q, 32'h08070605);
    check("t2_s_ready_freed", s_ready, 1);
    pop();
    check("t2_q_valid_empty", q_valid, 0);

    // 3: short sequence padded
    beat(8'h05, 0); beat(8'h06, 1);
    check("t3_q", q, 32'h00000605);
    check("t3_err_short", err_short, 1);
    check("t3_seq_cnt", seq_cnt, 4);
    cyc();
    check("t3_err_short_clr", err_short, 0);
    pop();

    // 4: long sequence, extras dropped
    beat(8'h01, 0); beat(8'h02, 0); beat(8'h03, 0); beat(8'h04, 0);
    check("t4_q_valid", q_valid, 1);
    check("t4_q", q, 32'h04030201);
    check("t4_err_long_early", err_long, 0);
    beat(8'h05, 0);
    check("t4_err_long", err_long, 1);
    beat(8'h06, 1);
    check("t4_err_long_clr", err_long, 0);
    check("t4_q_stable", q, 32'h04030201);
    check("t4_seq_cnt", seq_cnt, 5);
    check("t4_err_short", err_short, 0);
    pop();
    beat(8'h0A, 0); beat(8'h0B, 0); beat(8'h0C, 0); beat(8'h0D, 1);
    check("t4_q_next", q, 32'h0D0C0B0A);
    check("t4_seq_cnt_next", seq_cnt, 6);
    pop();

    // 5: out-of-range ID replaced
    beat(8'h10, 0);
    check("t5_err_range_idle", err_range, 0);
    beat(8'hFA, 0);
    check("t5_err_range", err_range, 1);
    beat(8'h12, 0);
    check("t5_err_range_clr", err_range, 0);
    beat(8'h13, 1);
    check("t5_q", q, 32'h13120010);
    check("t5_seq_cnt", seq_cnt, 7);
    pop();

    // 6: reset mid-sequence
    beat(8'h21, 0); beat(8'h22, 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_q_valid", q_valid, 0);
    check("t6_rst_seq_cnt", seq_cnt, 0);
    check("t6_rst_s_ready", s_ready, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    beat(8'h21, 0); beat(8'h22, 0); beat(8'h23, 0); beat(8'h24, 1);
    check("t6_q", q, 32'h24232221);
    check("t6_seq_cnt", seq_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/char_seq_loader.md
Name: char_seq_loader

Overview:
- Upstream feeder for emb_layer.
- Accepts a byte-serial stream of character IDs (valid/ready, with end-of-sequence marker).
- Packs N IDs into one N*CHAR_LEN word, double-buffered (ping-pong), and presents it as the emb_layer d_forward operand.
- The training sequencer pops a word with q_ready, in the same cycle it pulses run_forward; the next sequence loads meanwhile.

Parameters:
- N, `N: characters per sequence.
- CHAR_LEN, `CHAR_LEN: bits per character ID.
- CHAR_NUM, `CHAR_NUM: vocabulary size; legal IDs are 0..CHAR_NUM-1.
- PAD_ID, 0: substitute ID for padding and for out-of-range characters.
- CNT_WIDTH, 16: width of the completed-sequence counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- s_valid  input  1  input character valid.
- s_data  input  CHAR_LEN  input character ID.
- s_last  input  1  last character of the sequence.
- s_ready  output  1  loader accepts the beat.
- q_valid  output  1  packed sequence available.
- q_ready  input  1  consumer pops the sequence.
- q  output  N*CHAR_LEN  packed sequence; char k at bits [k*CHAR_LEN +: CHAR_LEN].
- err_short  output  1  pulse: s_last arrived before N characters.
- err_long  output  1  pulse: more than N characters in a sequence.
- err_range  output  1  pulse: ID >= CHAR_NUM was replaced.
- seq_cnt  output  CNT_WIDTH  completed sequences, wraps to 0.

Behaviour:
- Reset values: all outputs 0 (s_ready 0 during reset). Both slots zeroed, slot_valid=00, wr_sel=rd_sel=0, char index=0, state FILL. s_ready goes to 1 on the first cycle after release.
- Beat accepted when s_valid & s_ready.
- Writer FSM, state FILL:
  - s_ready = ~slot_valid[wr_sel].
  - An accepted beat writes its ID into slot[wr_sel] at the current index, then increments the index.
  - Completion occurs on whichever comes first: s_last, or the beat at index N-1.
  - On completion: set slot_valid[wr_sel], toggle wr_sel, index<=0, seq_cnt+1.
- Short sequence (s_last at index < N-1): positions index+1..N-1 are written PAD_ID in the same cycle. err_short pulses the next cycle.
- Long sequence (beat at index N-1 without s_last): the sequence completes normally and the FSM moves to DISCARD.
- State DISCARD:
  - s_ready=1; accepted beats are dropped and do not affect slots.
  - err_long pulses once, on the cycle after the first dropped beat.
  - An accepted beat with s_last returns the FSM to FILL.
- Range check: accepted ID >= CHAR_NUM is stored as PAD_ID, and err_range pulses the next cycle. Not checked in DISCARD.
- Reader:
  - q = slot[rd_sel]; q_valid = slot_valid[rd_sel].
  - q_ready & q_valid clears slot_valid[rd_sel] and toggles rd_sel.
  - q_ready while q_valid=0 is ignored.
- Latency: q_valid rises the cycle after the completing beat is accepted.
- q is stable while q_valid=1 and not popped.
- Simultaneous pop and completion:
  - Both take effect; they always target different slots unless both are free.
  - A slot freed by a pop makes s_ready=1 on the next cycle, not combinationally.
- Both slots full: s_ready=0 and the input stalls; no data is lost.
- Error pulses are registered, 1 cycle wide, and independent of each other.
- seq_cnt wraps from 2^CNT_WIDTH-1 to 0.
- Reset mid-operation: everything returns to reset values immediately; any partial sequence is discarded.

Test Plan:
(all with N=4, CHAR_LEN=8, CHAR_NUM=200, PAD_ID=0)
1. Beats 03,07,09,0B with s_last on 4th, q_ready=0 -> q_valid=1 the cycle after 4th beat; q=0x0B090703; s_ready stays 1; seq_cnt=1.
2. Two full sequences (01..04, 05..08), q_ready=0 -> s_ready=0 after second completes; 9th beat stalls. Pulse q_ready -> next cycle q=0x08070605 and s_ready=1. Second pop -> q_valid=0.
3. Short: beats 05,06(last) -> q=0x00000605; err_short pulses once; seq_cnt+1.
4. Long: beats 01..06, last on 06 -> q=0x04030201; err_long pulses one cycle after beat 05; beats 05,06 dropped. Following 0A,0B,0C,0D(last) -> q=0x0D0C0B0A.
5. Range: beats 0x10,0xFA,0x12,0x13(last) -> q=0x13120010; err_range pulses once.
6. Reset asserted after 2 beats, then released -> q_valid=0, seq_cnt=0. A new sequence 21,22,23,24 -> q=0x24232221.
